gate_response_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 24 ++
 rtl/gate_chk_bitstat.sv | 40 ++++
 rtl/gate_response_checker.sv | 151 +++++++++++++++
 tb/tb_gate_response_checker.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate response checker: FSM states, the
// "no mismatch seen" marker and a width-generic saturating increment.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counters are at most this wide; narrower users slice/cast down.
  localparam int MAX_CNT_W = 32;
  localparam logic [MAX_CNT_W-1:0] FIRST_NONE = '1;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned w);
    logic [MAX_CNT_W-1:0] lim;
    lim = FIRST_NONE >> (MAX_CNT_W - w);
    return (v == lim) ? v : v + 1;
  endfunction

endpackage

// File: rtl/gate_chk_bitstat.sv
// Per-output statistics: saturating mismatch count plus sticky index of the first mismatch.
// Updates on the edge where i_en && i_mism; values visible the following cycle.
module gate_chk_bitstat
  import gate_chk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_mism,
  input  logic [CNT_W-1:0] i_sample_idx,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_first
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_first;
  logic             r_hit;

  // A separate hit flag keeps the capture sticky even if the index itself is all-ones.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt   <= '0;
      r_first <= FIRST_NONE[CNT_W-1:0];
      r_hit   <= 1'b0;
    end else if (i_en && i_mism) begin
      r_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(r_cnt), CNT_W));
      if (!r_hit) begin
        r_first <= i_sample_idx;
        r_hit   <= 1'b1;
      end
    end
  end

  assign o_count = r_cnt;
  assign o_first = r_first;

endmodule

// File: rtl/gate_response_checker.sv
// Compares DUT vs golden vectors per sampled cycle, then streams one record per output
// over valid/ready (held while !rpt_ready). Optional ref_mask port: GATE_CHK_XMASK_EN.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_OUT = 7,
  parameter int CNT_W = 16,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [N_OUT-1:0] ref_vec,
  input  logic [N_OUT-1:0] dut_vec,
`ifdef GATE_CHK_XMASK_EN
  input  logic [N_OUT-1:0] ref_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_idx,
  output logic [CNT_W-1:0] rpt_count,
  output logic [CNT_W-1:0] rpt_first
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clear;
  logic             w_sample;
  logic             w_rpt_hs;
  logic             w_last;
  logic [N_OUT-1:0] w_mism;

  logic [CNT_W-1:0] r_samples;
  logic [CNT_W-1:0] r_errors;
  logic [CNT_W-1:0] r_first_err;
  logic             r_err_hit;
  logic [IDX_W-1:0] r_rpt_idx;

  logic [CNT_W-1:0] w_cnt   [N_OUT];
  logic [CNT_W-1:0] w_first [N_OUT];

`ifdef GATE_CHK_XMASK_EN
  // Masked bits stand for unknown reference values and never count as mismatches.
  assign w_mism = (ref_vec ^ dut_vec) & ~ref_mask;
`else
  assign w_mism = ref_vec ^ dut_vec;
`endif

  assign w_last = (r_rpt_idx == IDX_W'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_sample    = 1'b0;
    w_rpt_hs    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rpt_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        w_sample = sample_en;
        if (stop) w_state_nxt = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        rpt_valid = 1'b1;
        if (rpt_ready) begin
          w_rpt_hs = 1'b1;
          if (w_last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // First-error index takes the pre-increment sample count, so sample 0 is index 0.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_samples   <= '0;
      r_errors    <= '0;
      r_first_err <= FIRST_NONE[CNT_W-1:0];
      r_err_hit   <= 1'b0;
    end else if (w_sample) begin
      r_samples <= CNT_W'(sat_inc(MAX_CNT_W'(r_samples), CNT_W));
      if (|w_mism) begin
        r_errors <= CNT_W'(sat_inc(MAX_CNT_W'(r_errors), CNT_W));
        if (!r_err_hit) begin
          r_first_err <= r_samples;
          r_err_hit   <= 1'b1;
        end
      end
    end
  end

  // Index parks on the last record after its handshake rather than running off the end.
  always_ff @(posedge clk) begin
    if (reset || w_clear)        r_rpt_idx <= '0;
    else if (w_rpt_hs && !w_last) r_rpt_idx <= r_rpt_idx + IDX_W'(1);
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_bit
    gate_chk_bitstat #(
      .CNT_W(CNT_W)
    ) u_bitstat (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_clear),
      .i_en        (w_sample),
      .i_mism      (w_mism[g]),
      .i_sample_idx(r_samples),
      .o_count     (w_cnt[g]),
      .o_first     (w_first[g])
    );
  end

  assign samples   = r_samples;
  assign errors    = r_errors;
  assign first_err = r_first_err;
  assign pass      = (r_state == DONE) && (r_errors == '0);
  assign rpt_idx   = r_rpt_idx;
  assign rpt_count = w_cnt[r_rpt_idx];
  assign rpt_first = w_first[r_rpt_idx];

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: a per-cycle vector table plus hand-written multi-cycle scenarios;
// a 4-bit-counter instance shares the stimulus for the saturation case.
module tb_gate_response_checker;

  logic        clk = 1'b0;
  logic        reset, start, stop, sample_en, rpt_ready;
  logic [6:0]  ref_vec, dut_vec;
`ifdef GATE_CHK_XMASK_EN
  logic [6:0]  ref_mask;
`endif
  logic        busy, done, pass, rpt_valid;
  logic [15:0] samples, errors, first_err, rpt_count, rpt_first;
  logic [2:0]  rpt_idx;
  logic        s_busy, s_done, s_pass, s_rpt_valid;
  logic [3:0]  s_samples, s_errors, s_first_err, s_rpt_count, s_rpt_first;
  logic [2:0]  s_rpt_idx;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt   [7];
  logic [15:0] exp_first [7];

  always #5 clk = ~clk;

  gate_response_checker #(.N_OUT(7), .CNT_W(16), .IDX_W(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .ref_vec(ref_vec), .dut_vec(dut_vec),
`ifdef GATE_CHK_XMASK_EN
    .ref_mask(ref_mask),
`endif
    .busy(busy), .done(done), .pass(pass), .samples(samples), .errors(errors),
    .first_err(first_err), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_idx(rpt_idx), .rpt_count(rpt_count), .rpt_first(rpt_first)
  );

  gate_response_checker #(.N_OUT(7), .CNT_W(4), .IDX_W(3)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .ref_vec(ref_vec), .dut_vec(dut_vec),
`ifdef GATE_CHK_XMASK_EN
    .ref_mask(ref_mask),
`endif
    .busy(s_busy), .done(s_done), .pass(s_pass), .samples(s_samples), .errors(s_errors),
    .first_err(s_first_err), .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
    .rpt_idx(s_rpt_idx), .rpt_count(s_rpt_count), .rpt_first(s_rpt_first)
  );

  typedef struct {
    logic        start, stop, sen, rdy;
    logic [6:0]  ref_v, dut_v;
    logic        busy, done, pass, rv;
    logic [15:0] samples, errors, first_err;
    logic [2:0]  idx;
    logic [15:0] cnt, first;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input int st, input int sp, input int se, input int rd,
                              input int rf, input int du, input int b, input int d,
                              input int p, input int rv, input int s, input int e,
                              input int f, input int ix, input int c, input int fr);
    vec_t v;
    v.start = 1'(st); v.stop = 1'(sp); v.sen = 1'(se); v.rdy = 1'(rd);
    v.ref_v = 7'(rf); v.dut_v = 7'(du);
    v.busy = 1'(b); v.done = 1'(d); v.pass = 1'(p); v.rv = 1'(rv);
    v.samples = 16'(s); v.errors = 16'(e); v.first_err = 16'(f);
    v.idx = 3'(ix); v.cnt = 16'(c); v.first = 16'(fr);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic samp(input logic [6:0] r, input logic [6:0] d);
    sample_en = 1'b1;
    ref_vec   = r;
    dut_vec   = d;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 7; i++) begin
      exp_cnt[i]   = 16'd0;
      exp_first[i] = 16'hFFFF;
    end
  endtask

  // Drains all records with rpt_ready held high; expects DONE afterwards.
  task automatic run_report(input string tag);
    rpt_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s rv%0d", tag, k), 16'(rpt_valid), 16'd1);
      chk($sformatf("%s idx%0d", tag, k), 16'(rpt_idx), 16'(k));
      chk($sformatf("%s cnt%0d", tag, k), rpt_count, exp_cnt[k]);
      chk($sformatf("%s first%0d", tag, k), rpt_first, exp_first[k]);
      tick();
    end
    rpt_ready = 1'b0;
    chk({tag, " rv_end"}, 16'(rpt_valid), 16'd0);
    chk({tag, " done"}, 16'(done), 16'd1);
    chk({tag, " busy_end"}, 16'(busy), 16'd0);
  endtask

  initial begin
    localparam int FN = 'hFFFF;
    logic [6:0] r;
    //            st sp se rd  ref    dut    b  d  p  rv s  e  f   ix c  first
    tbl[0]  = mk(1, 0, 0, 0, 0,     0,     1, 0, 0, 0, 0, 0, FN, 0, 0, FN);
    tbl[1]  = mk(0, 0, 1, 0, 'h55,  'h55,  1, 0, 0, 0, 1, 0, FN, 0, 0, FN);
    tbl[2]  = mk(0, 0, 0, 0, 0,     'h7f,  1, 0, 0, 0, 1, 0, FN, 0, 0, FN);
    tbl[3]  = mk(0, 0, 1, 0, 'h2a,  'h2a,  1, 0, 0, 0, 2, 0, FN, 0, 0, FN);
    tbl[4]  = mk(0, 0, 1, 0, 0,     0,     1, 0, 0, 0, 3, 0, FN, 0, 0, FN);
    tbl[5]  = mk(0, 0, 1, 0, 'h7f,  'h7f,  1, 0, 0, 0, 4, 0, FN, 0, 0, FN);
    tbl[6]  = mk(0, 0, 1, 0, 'h01,  'h01,  1, 0, 0, 0, 5, 0, FN, 0, 0, FN);
    tbl[7]  = mk(0, 0, 1, 0, 'h10,  'h15,  1, 0, 0, 0, 6, 1, 5,  0, 1, 5);
    tbl[8]  = mk(1, 0, 1, 0, 'h33,  'h33,  1, 0, 0, 0, 7, 1, 5,  0, 1, 5);
    tbl[9]  = mk(0, 1, 1, 0, 0,     'h01,  1, 0, 0, 1, 8, 2, 5,  0, 2, 5);
    tbl[10] = mk(0, 1, 1, 1, 0,     'h7f,  1, 0, 0, 1, 8, 2, 5,  1, 0, FN);
    tbl[11] = mk(1, 0, 0, 0, 0,     0,     1, 0, 0, 1, 8, 2, 5,  1, 0, FN);
    tbl[12] = mk(0, 0, 0, 1, 0,     0,     1, 0, 0, 1, 8, 2, 5,  2, 1, 5);
    tbl[13] = mk(0, 0, 0, 1, 0,     0,     1, 0, 0, 1, 8, 2, 5,  3, 0, FN);
    tbl[14] = mk(0, 0, 0, 1, 0,     0,     1, 0, 0, 1, 8, 2, 5,  4, 0, FN);
    tbl[15] = mk(0, 0, 0, 1, 0,     0,     1, 0, 0, 1, 8, 2, 5,  5, 0, FN);
    tbl[16] = mk(0, 0, 0, 1, 0,     0,     1, 0, 0, 1, 8, 2, 5,  6, 0, FN);
    tbl[17] = mk(0, 0, 0, 1, 0,     0,     0, 1, 0, 0, 8, 2, 5,  0, 0, FN);
    tbl[18] = mk(0, 0, 1, 0, 0,     'h7f,  0, 1, 0, 0, 8, 2, 5,  0, 0, FN);

    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b0; rpt_ready = 1'b0;
    ref_vec = '0; dut_vec = '0;
`ifdef GATE_CHK_XMASK_EN
    ref_mask = '0;
`endif
    tick();
    tick();
    reset = 1'b0;

    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst pass", 16'(pass), 16'd0);
    chk("rst rpt_valid", 16'(rpt_valid), 16'd0);
    chk("rst rpt_idx", 16'(rpt_idx), 16'd0);
    chk("rst samples", samples, 16'd0);
    chk("rst errors", errors, 16'd0);
    chk("rst first_err", first_err, 16'hFFFF);
    chk("rst rpt_count", rpt_count, 16'd0);
    chk("rst rpt_first", rpt_first, 16'hFFFF);

    samp(7'h00, 7'h7f);
    chk("idle sample samples", samples, 16'd0);
    chk("idle sample errors", errors, 16'd0);

    // Multi-bit mismatch, ignored start, stop+sample, report stall, DONE hold.
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; sample_en = tbl[i].sen;
      rpt_ready = tbl[i].rdy; ref_vec = tbl[i].ref_v; dut_vec = tbl[i].dut_v;
      tick();
      chk($sformatf("tbl%0d busy", i), 16'(busy), 16'(tbl[i].busy));
      chk($sformatf("tbl%0d done", i), 16'(done), 16'(tbl[i].done));
      chk($sformatf("tbl%0d pass", i), 16'(pass), 16'(tbl[i].pass));
      chk($sformatf("tbl%0d rv", i), 16'(rpt_valid), 16'(tbl[i].rv));
      chk($sformatf("tbl%0d samples", i), samples, tbl[i].samples);
      chk($sformatf("tbl%0d errors", i), errors, tbl[i].errors);
      chk($sformatf("tbl%0d first_err", i), first_err, tbl[i].first_err);
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d idx", i), 16'(rpt_idx), 16'(tbl[i].idx));
        chk($sformatf("tbl%0d cnt", i), rpt_count, tbl[i].cnt);
        chk($sformatf("tbl%0d first", i), rpt_first, tbl[i].first);
      end
    end
    start = 1'b0; stop = 1'b0; sample_en = 1'b0; rpt_ready = 1'b0;

    // Clean run of 200 samples.
    pulse_start();
    chk("clean cleared samples", samples, 16'd0);
    chk("clean cleared first_err", first_err, 16'hFFFF);
    for (int s = 0; s < 200; s++) begin
      r = 7'($urandom);
      samp(r, r);
    end
    pulse_stop();
    clr_exp();
    run_report("clean");
    chk("clean pass", 16'(pass), 16'd1);
    chk("clean samples", samples, 16'd200);
    chk("clean errors", errors, 16'd0);
    chk("clean first_err", first_err, 16'hFFFF);

    // Bit 6 inverted on samples 3 and 10.
    pulse_start();
    for (int s = 0; s < 12; s++) begin
      r = 7'($urandom);
      samp(r, (s == 3 || s == 10) ? (r ^ 7'h40) : r);
    end
    chk("b6 samples", samples, 16'd12);
    chk("b6 errors", errors, 16'd2);
    chk("b6 first_err", first_err, 16'd3);
    pulse_stop();
    clr_exp();
    exp_cnt[6] = 16'd2; exp_first[6] = 16'd3;
    run_report("b6");
    chk("b6 pass", 16'(pass), 16'd0);

    // Backpressure on idx 2 with stop/sample_en noise during REPORT.
    pulse_start();
    samp(7'h00, 7'h10);
    samp(7'h00, 7'h04);
    samp(7'h11, 7'h11);
    pulse_stop();
    clr_exp();
    exp_cnt[4] = 16'd1; exp_first[4] = 16'd0;
    exp_cnt[2] = 16'd1; exp_first[2] = 16'd1;
    rpt_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        rpt_ready = 1'b0; stop = 1'b1; sample_en = 1'b1;
        ref_vec = 7'h00; dut_vec = 7'h7f;
        for (int j = 0; j < 4; j++) begin
          tick();
          chk($sformatf("bp stall%0d rv", j), 16'(rpt_valid), 16'd1);
          chk($sformatf("bp stall%0d idx", j), 16'(rpt_idx), 16'd2);
          chk($sformatf("bp stall%0d cnt", j), rpt_count, 16'd1);
          chk($sformatf("bp stall%0d first", j), rpt_first, 16'd1);
          chk($sformatf("bp stall%0d samples", j), samples, 16'd3);
          chk($sformatf("bp stall%0d errors", j), errors, 16'd2);
        end
        stop = 1'b0; sample_en = 1'b0; rpt_ready = 1'b1;
      end
      chk($sformatf("bp idx%0d", k), 16'(rpt_idx), 16'(k));
      chk($sformatf("bp cnt%0d", k), rpt_count, exp_cnt[k]);
      chk($sformatf("bp first%0d", k), rpt_first, exp_first[k]);
      chk($sformatf("bp notdone%0d", k), 16'(done), 16'd0);
      tick();
    end
    rpt_ready = 1'b0;
    chk("bp done", 16'(done), 16'd1);
    chk("bp pass", 16'(pass), 16'd0);
    chk("bp samples", samples, 16'd3);
    chk("bp errors", errors, 16'd2);
    chk("bp first_err", first_err, 16'd0);

    // Saturation on the 4-bit instance, then reset in the middle of REPORT.
    pulse_start();
    for (int s = 0; s < 20; s++) samp(7'h00, 7'h01);
    chk("sat main samples", samples, 16'd20);
    chk("sat main errors", errors, 16'd20);
    chk("sat samples", 16'(s_samples), 16'd15);
    chk("sat errors", 16'(s_errors), 16'd15);
    chk("sat first_err", 16'(s_first_err), 16'd0);
    pulse_stop();
    chk("sat rpt_count", 16'(s_rpt_count), 16'd15);
    chk("sat rpt_first", 16'(s_rpt_first), 16'd0);
    chk("sat main rpt_count", rpt_count, 16'd20);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk("midrpt idx", 16'(rpt_idx), 16'd1);
    reset = 1'b1;
    tick();
    chk("midrst busy", 16'(busy), 16'd0);
    chk("midrst rv", 16'(rpt_valid), 16'd0);
    chk("midrst idx", 16'(rpt_idx), 16'd0);
    chk("midrst samples", samples, 16'd0);
    chk("midrst errors", errors, 16'd0);
    chk("midrst first_err", first_err, 16'hFFFF);
    chk("midrst rpt_count", rpt_count, 16'd0);
    chk("midrst rpt_first", rpt_first, 16'hFFFF);
    chk("midrst sat samples", 16'(s_samples), 16'd0);
    reset = 1'b0;
    tick();
    chk("postrst done", 16'(done), 16'd0);
    chk("postrst busy", 16'(busy), 16'd0);
    chk("postrst rv", 16'(rpt_valid), 16'd0);

`ifdef GATE_CHK_XMASK_EN
    // Bit 1 always mismatches but is masked as unknown.
    ref_mask = 7'h02;
    pulse_start();
    for (int s = 0; s < 10; s++) begin
      r = 7'($urandom);
      samp(r, r ^ 7'h02);
    end
    pulse_stop();
    chk("xmask errors", errors, 16'd0);
    chk("xmask samples", samples, 16'd10);
    clr_exp();
    run_report("xmask");
    chk("xmask pass", 16'(pass), 16'd1);
    ref_mask = 7'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
